// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/WB control sequencer for a 16-bit MIPS-style datapath.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_sequencer #(
   parameter int PC_WIDTH  = 8,
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [15:0]          imem_data,
   output logic                 reg_write,
   output logic [3:0]           alu_control,
   output logic                 alu_src,
   output logic [3:0]           rd_addr,
   output logic [3:0]           rs_addr,
   output logic [3:0]           rt_addr,
   output logic                 busy,
   output logic                 halted,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] instr_count
);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALTED, FAULT} state_t;

   state_t              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [15:0]         ir_q;
   logic [WW-1:0]       wait_q;
   logic                req_q, wr_q, src_q, busy_q, halted_q, fault_q;
   logic [3:0]          ctl_q;
   logic                alu_op, dec_src;
   logic [3:0]          dec_ctl;

   always_comb begin
      alu_op  = 1'b1;
      dec_ctl = 4'b0000;
      dec_src = 1'b0;
      case (ir_q[15:12])
         4'h0: dec_ctl = 4'b0010;
         4'h1: dec_ctl = 4'b0110;
         4'h2: begin dec_ctl = 4'b0010; dec_src = 1'b1; end
         4'h3: dec_ctl = 4'b0000;
         4'h4: dec_ctl = 4'b0001;
         4'h5: dec_ctl = 4'b0111;
         default: alu_op = 1'b0;
      endcase
   end

`ifdef PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else if (state_q == WB || (state_q == DECODE && ir_q[15:12] == 4'hE))
         cnt_q <= cnt_q + 1'b1;
   end
   assign instr_count = cnt_q;
`else
   assign instr_count = '0;
`endif

   // Outputs are registered: each transition loads the values for the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         wait_q   <= '0;
         req_q    <= 1'b0;
         wr_q     <= 1'b0;
         ctl_q    <= 4'b0000;
         src_q    <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         req_q    <= 1'b0;
         wr_q     <= 1'b0;
         ctl_q    <= 4'b0000;
         src_q    <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         case (state_q)
            IDLE, HALTED, FAULT: begin
               if (start) begin
                  state_q <= FETCH;
                  pc_q    <= '0;
                  wait_q  <= '0;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  halted_q <= state_q == HALTED;
                  fault_q  <= state_q == FAULT;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  ir_q    <= imem_data;
                  pc_q    <= pc_q + 1'b1;
                  wait_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= DECODE;
               end else if (wait_q == WAIT_MAX) begin
                  wait_q  <= '0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end else begin
                  wait_q <= wait_q + 1'b1;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            DECODE: begin
               if (alu_op) begin
                  ctl_q   <= dec_ctl;
                  src_q   <= dec_src;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end else if (ir_q[15:12] == 4'hE) begin
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end else if (ir_q[15:12] == 4'hF) begin
                  halted_q <= 1'b1;
                  state_q  <= HALTED;
               end else begin
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end
            end
            EXEC: begin
               wr_q    <= 1'b1;
               ctl_q   <= ctl_q;
               src_q   <= src_q;
               busy_q  <= 1'b1;
               state_q <= WB;
            end
            WB: begin
               req_q   <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= FETCH;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign reg_write   = wr_q;
   assign alu_control = ctl_q;
   assign alu_src     = src_q;
   assign rd_addr     = ir_q[11:8];
   assign rs_addr     = ir_q[7:4];
   assign rt_addr     = ir_q[3:0];
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign fault       = fault_q;
endmodule
